tinyqv_cmp_counter: RTL

// Nibble-serial up-counter with programmable increment, serial load and

---
 rtl/tinyqv_cmp_counter.sv | 109 ++++++++++
 1 files changed

// File: rtl/tinyqv_cmp_counter.sv
// Nibble-serial up-counter with programmable increment, serial load and
// optional compare interrupt (mcycle/minstret/mtime + mtimecmp style).
module tinyqv_cmp_counter #(
  parameter int NIBBLES = 8,
  parameter bit CMP_EN  = 1'b1,
  localparam int IB     = $clog2(NIBBLES)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [IB-1:0] nibble_idx,
  input  logic          add,
  input  logic [3:0]    inc,
  input  logic          wr_val,
  input  logic          wr_cmp,
  input  logic [3:0]    data_in,
  output logic [3:0]    data_out,
  output logic          cy_out,
  output logic          irq
);

  localparam int W = 4 * NIBBLES;

  logic [W-1:0] val_q;
  logic         carry_q;
  logic         first;
  logic         last;
  logic [3:0]   cin;
  logic [4:0]   sum;
  logic [3:0]   val_nib;
  logic         carry_next;

  assign first = (nibble_idx == '0);
  assign last  = (nibble_idx == IB'(NIBBLES - 1));

  always_comb begin
    cin        = '0;
    sum        = '0;
    val_nib    = '0;
    carry_next = 1'b0;
    if (first) begin
      cin = add ? inc : 4'h0;
    end else begin
      cin = {3'b000, carry_q};
    end
    sum = {1'b0, val_q[3:0]} + {1'b0, cin};
    // A load overrides the increment and kills the ripple out of this nibble.
    if (wr_val) begin
      val_nib    = data_in;
      carry_next = 1'b0;
    end else begin
      val_nib    = sum[3:0];
      carry_next = sum[4];
    end
  end

  assign data_out = val_nib;
  assign cy_out   = last & carry_next;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      val_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      val_q   <= {val_nib, val_q[W-1:4]};
      carry_q <= carry_next;
    end
  end

  if (CMP_EN) begin : g_cmp
    logic [W-1:0] cmp_q;
    logic [3:0]   cmp_nib;
    logic         ge_q;
    logic         ge_next;
    logic         irq_q;

    // LSB-first unsigned compare: a higher nibble that differs overrides
    // whatever the lower nibbles decided.
    always_comb begin
      cmp_nib = wr_cmp ? data_in : cmp_q[3:0];
      ge_next = ge_q;
      if (first) begin
        ge_next = (val_nib >= cmp_nib);
      end else if (val_nib > cmp_nib) begin
        ge_next = 1'b1;
      end else if (val_nib < cmp_nib) begin
        ge_next = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        cmp_q <= '1;
        ge_q  <= 1'b0;
        irq_q <= 1'b0;
      end else begin
        cmp_q <= {cmp_nib, cmp_q[W-1:4]};
        ge_q  <= ge_next;
        if (last) begin
          irq_q <= ge_next;
        end
      end
    end

    assign irq = irq_q;
  end else begin : g_nocmp
    assign irq = 1'b0;
  end

endmodule
